// File: rtl/seg_scan_driver_if.sv
// Bus bundle between a controller and the seven-segment scan driver.
// The controller (master) supplies the value, load strobe and display
// controls; the driver (slave) returns the digit nibble, anode selects
// and the frame pulse.
interface seg_scan_driver_if;
    logic        en;
    logic        load;
    logic [31:0] data;
    logic        blank_lz;
    logic [3:0]  num;
    logic [7:0]  an;
    logic        frame;

    modport master (
        output en,
        output load,
        output data,
        output blank_lz,
        input  num,
        input  an,
        input  frame
    );

    modport slave (
        input  en,
        input  load,
        input  data,
        input  blank_lz,
        output num,
        output an,
        output frame
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
// A prescaler divides the clock into digit slots; each slot presents one
// nibble of the displayed value on num together with an active-low anode
// select. New values wait in a hold register and are copied into the
// displayed register only when the scan wraps, so a frame is never torn.
module seg_scan_driver #(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   bus
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [31:0]       hold_q,    hold_d;
    logic [31:0]       disp_q,    disp_d;
    logic              pending_q, pending_d;
    logic              wrap_q,    wrap_d;
    logic [3:0]        num_q,     num_d;
    logic [7:0]        an_q,      an_d;
    logic              frame_q,   frame_d;

    logic              tick;
    logic              boundary;
    logic              zero_run;
    logic [DIGITS-1:0] upper_zero;
    logic              blank_cur;

    // Prescaler, digit index and the double-buffered value path.
    always_comb begin
        tick      = 1'b0;
        boundary  = 1'b0;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        disp_d    = disp_q;
        pending_d = pending_q;

        if (bus.en) begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (tick) begin
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                boundary = 1'b1;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (bus.load) begin
            hold_d    = bus.data;
            pending_d = 1'b1;
        end

        // A load landing on the wrapping tick bypasses the hold register.
        if (boundary) begin
            if (bus.load) begin
                disp_d    = bus.data;
                pending_d = 1'b0;
            end else if (pending_q) begin
                disp_d    = hold_q;
                pending_d = 1'b0;
            end
        end

        wrap_d = boundary;
    end

    // Output values derived from the current digit index and displayed value.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (disp_q[4*i +: 4] == 4'd0);
            upper_zero[i] = zero_run;
        end

        blank_cur = bus.blank_lz && (idx_q != '0) && upper_zero[idx_q];

        num_d = disp_q[{idx_q, 2'b00} +: 4];

        an_d = 8'hFF;
        if (bus.en && !blank_cur) begin
            an_d[idx_q] = 1'b0;
        end

        frame_d = wrap_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            wrap_q    <= 1'b0;
            num_q     <= 4'd0;
            an_q      <= 8'hFF;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            wrap_q    <= wrap_d;
            num_q     <= num_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.num   = num_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver. A reference model tracks the scan
// position as a count of enabled cycles and pushes the expected outputs
// for every edge into a queue; a monitor on the falling edge pops and
// compares against the DUT.
module tb_seg_scan_driver;

    localparam int DIGITS = 8;
    localparam int DIV    = 4;
    localparam int FRAME_LEN = DIGITS * DIV;

    typedef struct {
        logic [3:0] num;
        logic [7:0] an;
        logic       frame;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cycle;

    seg_scan_driver_if bus_if();

    seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: position counts enabled cycles since reset.
    int unsigned m_pos;
    logic [31:0] m_disp;
    logic [31:0] m_latest;
    bit          m_pend;
    bit          m_frame;
    exp_t        exp_q[$];

    // Reference model: expected outputs for this edge from the state before it,
    // then advance the model using the inputs sampled at this edge.
    always @(posedge clk) begin
        exp_t e;
        int   idx;
        bit   boundary;
        bit   blanked;
        if (!rst_n) begin
            e.num    = 4'h0;
            e.an     = 8'hFF;
            e.frame  = 1'b0;
            m_pos    = 0;
            m_disp   = 32'h0;
            m_latest = 32'h0;
            m_pend   = 1'b0;
            m_frame  = 1'b0;
        end else begin
            idx     = (m_pos / DIV) % DIGITS;
            e.num   = 4'((m_disp >> (4 * idx)) & 32'hF);
            blanked = bus_if.blank_lz && (idx != 0) && ((m_disp >> (4 * idx)) == 32'h0);
            if (bus_if.en && !blanked)
                e.an = ~(8'h01 << idx);
            else
                e.an = 8'hFF;
            e.frame  = m_frame;
            boundary = 1'b0;
            if (bus_if.en) begin
                m_pos++;
                boundary = ((m_pos % FRAME_LEN) == 0);
            end
            if (bus_if.load) begin
                m_latest = bus_if.data;
                m_pend   = 1'b1;
            end
            if (boundary && m_pend) begin
                m_disp = m_latest;
                m_pend = 1'b0;
            end
            m_frame = boundary;
        end
        exp_q.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycle, actual, expected);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("num",   {4'h0, bus_if.num},   {4'h0, e.num});
            checkOutput("an",    bus_if.an,            e.an);
            checkOutput("frame", {7'h0, bus_if.frame}, {7'h0, e.frame});
        end
    end

    logic cur_en;
    logic cur_blank;

    // Drive one cycle of inputs; values are sampled at the next rising edge.
    task automatic applyStimulus(input logic rst_v, input logic en_v, input logic load_v,
                                 input logic [31:0] data_v, input logic blank_v);
        rst_n           = rst_v;
        bus_if.en       = en_v;
        bus_if.load     = load_v;
        bus_if.data     = data_v;
        bus_if.blank_lz = blank_v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, cur_en, 1'b0, 32'h0, cur_blank);
    endtask

    task automatic loadValue(input logic [31:0] value);
        applyStimulus(1'b1, cur_en, 1'b1, value, cur_blank);
    endtask

    // Advance until the model position modulo modv equals target (bounded).
    task automatic waitPos(input int modv, input int target);
        for (int i = 0; i < 4 * FRAME_LEN; i++) begin
            if ((m_pos % modv) == target) return;
            idle(1);
        end
        checks++;
        errors++;
        $display("[TB] FAIL waitPos timeout: got pos %0d expected mod %0d == %0d", m_pos, modv, target);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        cur_en    = 1'b1;
        cur_blank = 1'b0;

        // Reset with enable high, then the basic digit sequence.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        loadValue(32'h76543210);
        idle(2 * FRAME_LEN + 8);

        // Tear-free update mid-frame, then a load on the wrapping tick.
        loadValue(32'h11111111);
        idle(FRAME_LEN + 2);
        waitPos(FRAME_LEN, 3 * DIV);
        loadValue(32'hAAAAAAAA);
        idle(FRAME_LEN + 4);
        loadValue(32'h11111111);
        idle(FRAME_LEN + 2);
        waitPos(FRAME_LEN, FRAME_LEN - 1);
        loadValue(32'hAAAAAAAA);
        idle(FRAME_LEN);

        // Leading-zero suppression.
        cur_blank = 1'b1;
        loadValue(32'h00000305);
        idle(2 * FRAME_LEN + 2);
        loadValue(32'h00000000);
        idle(2 * FRAME_LEN + 2);
        cur_blank = 1'b0;
        loadValue(32'h76543210);
        idle(FRAME_LEN + 2);

        // Enable freeze mid-slot on digit 5, with a load while frozen.
        waitPos(FRAME_LEN, 5 * DIV + 1);
        cur_en = 1'b0;
        idle(4);
        loadValue(32'hCAFE0123);
        idle(5);
        cur_en = 1'b1;
        idle(FRAME_LEN + 8);

        // Reset while an update is pending.
        waitPos(FRAME_LEN, 10);
        loadValue(32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(2 * FRAME_LEN + 4);

        // Two loads within one frame: last write wins.
        waitPos(FRAME_LEN, 2);
        loadValue(32'h00000001);
        idle(3);
        loadValue(32'h00000002);
        idle(FRAME_LEN + 4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic        r_rst;
            logic        r_load;
            logic [31:0] r_data;
            r_rst     = ($urandom_range(0, 299) != 0);
            cur_en    = ($urandom_range(0, 9) != 0);
            cur_blank = ($urandom_range(0, 3) != 0);
            r_load    = ($urandom_range(0, 24) == 0);
            r_data    = $urandom >> (4 * $urandom_range(0, 7));
            applyStimulus(r_rst, cur_en, r_load, r_data, cur_blank);
        end

        cur_en = 1'b1;
        idle(4);
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected at most 1", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
